// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end: fetch FSM states and core-wide constants.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Canonical no-op (addi x0, x0, 0)
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory port of the fetch unit: one request channel, one response channel.
// Request: a transfer happens on a rising edge where imem_req_valid_o and imem_req_ready_i are both 1;
// once raised, valid and address stay stable until that edge. Response: imem_rsp_valid_i is a one-cycle
// strobe carrying imem_rsp_data_i, never sooner than the cycle after the accepting edge.
interface fetch_prefetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid_o;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_req_ready_i;
  logic            imem_rsp_valid_i;
  logic [XLEN-1:0] imem_rsp_data_i;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
  );
endinterface

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs; push while full is accepted only with a pop.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap at DEPTH on their own
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with a small prefetch buffer feeding the decode register; one request in flight,
// redirects flush the buffer and squash any response still owed by memory.
module fetch_prefetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4,
  localparam int             CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  fetch_prefetch_unit_if.master        imem,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  input  logic                         stall_d_i,
  output logic [XLEN-1:0]              instr_d_o,
  output logic [XLEN-1:0]              pc_d_o,
  output logic [XLEN-1:0]              pc_plus4_d_o,
  output logic                         valid_d_o,
  output fetch_state_e                 state,
  output logic [CW-1:0]                fifo_count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] fpc;
  logic            req_valid;
  logic            accept;
  logic            rsp_take;
  logic            load_d;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_pop;
  logic            bypass;
  logic [2*XLEN-1:0] head;

  assign state    = state_q;
  assign accept   = req_valid & imem.imem_req_ready_i;
  assign rsp_take = (state_q == ST_WAIT) & imem.imem_rsp_valid_i & ~redirect_i;
  assign load_d   = ~redirect_i & ~stall_d_i;
  assign fifo_pop = load_d & ~fifo_empty;
  assign bypass   = load_d & fifo_empty & rsp_take;
  assign fifo_push = rsp_take & ~bypass;

  assign imem.imem_req_valid_o = req_valid;
  assign imem.imem_req_addr_o  = fpc;

  // rst also gates the request so the bus is quiet while reset is held, yet the
  // first request appears in the very first cycle after release.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_valid = rst & (fifo_count < DEPTH_C) & ~redirect_i;
        if (req_valid && imem.imem_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.imem_rsp_valid_i) state_d = ST_IDLE;
        else if (redirect_i)       state_d = ST_WAIT_DROP;
      end
      ST_WAIT_DROP: begin
        if (imem.imem_rsp_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            fpc <= RESET_VECTOR;
    else if (redirect_i) fpc <= redirect_pc_i & ~XLEN'(3);
    else if (accept)     fpc <= fpc + XLEN'(4);
  end

  prefetch_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .push     (fifo_push),
    .push_data({imem.imem_rsp_data_i, fpc - XLEN'(4)}),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The response always belongs to fpc-4: fpc advanced on accept and cannot move again before the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_d_o    <= 1'b0;
      instr_d_o    <= '0;
      pc_d_o       <= '0;
      pc_plus4_d_o <= '0;
    end else if (redirect_i) begin
      valid_d_o <= 1'b0;
    end else if (!stall_d_i) begin
      if (fifo_pop) begin
        valid_d_o    <= 1'b1;
        instr_d_o    <= head[2*XLEN-1:XLEN];
        pc_d_o       <= head[XLEN-1:0];
        pc_plus4_d_o <= head[XLEN-1:0] + XLEN'(4);
      end else if (bypass) begin
        valid_d_o    <= 1'b1;
        instr_d_o    <= imem.imem_rsp_data_i;
        pc_d_o       <= fpc - XLEN'(4);
        pc_plus4_d_o <= fpc;
      end else begin
        valid_d_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: per-cycle vector table plus hand-written redirect/reset sequences.
module tb_fetch_prefetch_unit;
  import core_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              stall;
  logic [XLEN-1:0]   instr_d;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   pc_plus4_d;
  logic              valid_d;
  fetch_state_e      dut_state;
  logic [2:0]        fifo_count;

  always #5 clk = ~clk;

  fetch_prefetch_unit_if #(.XLEN(XLEN)) imem_bus ();

  fetch_prefetch_unit #(
    .XLEN(XLEN),
    .RESET_VECTOR(32'h0000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_bus.master),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .stall_d_i    (stall),
    .instr_d_o    (instr_d),
    .pc_d_o       (pc_d),
    .pc_plus4_d_o (pc_plus4_d),
    .valid_d_o    (valid_d),
    .state        (dut_state),
    .fifo_count   (fifo_count)
  );

  typedef struct {
    bit          stall;
    bit          ready;
    bit          inject;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_vd;
    logic [31:0] exp_pc;
    int          exp_cnt;
  } vec_t;

  vec_t        vt[26];
  int          n_vec = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [XLEN-1:0] exp_q[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_req(input string name, input bit v, input logic [31:0] a);
    check({name, "_req_valid"}, 32'(imem_bus.imem_req_valid_o), 32'(v));
    if (v) check({name, "_req_addr"}, imem_bus.imem_req_addr_o, a);
  endtask

  task automatic check_dec(input string name, input bit v, input logic [31:0] pc);
    check({name, "_valid_d"}, 32'(valid_d), 32'(v));
    check({name, "_pc_d"}, pc_d, pc);
    if (v) begin
      check({name, "_instr_d"}, instr_d, instr_of(pc));
      check({name, "_pc_plus4_d"}, pc_plus4_d, pc + 32'd4);
    end
  endtask

  task automatic check_state(input string name, input fetch_state_e s);
    check({name, "_state"}, 32'(dut_state), 32'(s));
  endtask

  // One cycle: drive inputs after the falling edge, play the memory, leave 1 ns for outputs to settle.
  task automatic step(input bit s, input bit r, input logic [31:0] rpc, input bit rdy, input bit inj);
    bit deliver;
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_bus.imem_req_ready_i = rdy;
    deliver = 1'b0;
    if (exp_q.size() != 0) begin
      if (pend_cnt == 0) deliver = 1'b1;
      else pend_cnt--;
    end
    imem_bus.imem_rsp_valid_i = deliver | inj;
    imem_bus.imem_rsp_data_i  = deliver ? instr_of(exp_q[0]) : 32'hDEAD_BEEF;
    if (deliver) void'(exp_q.pop_front());
    #1;
    if (rst && imem_bus.imem_req_valid_o && rdy) begin
      check("one_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.push_back(imem_bus.imem_req_addr_o);
      pend_cnt = lat - 1;
    end
  endtask

  task automatic add(input bit s, input bit rdy, input bit inj, input bit rq, input logic [31:0] a,
                     input bit vd, input logic [31:0] pc, input int cnt);
    vt[n_vec] = '{stall: s, ready: rdy, inject: inj, exp_req: rq, exp_addr: a,
                  exp_vd: vd, exp_pc: pc, exp_cnt: cnt};
    n_vec++;
  endtask

  initial begin
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_bus.imem_req_ready_i = 1'b0;
    imem_bus.imem_rsp_valid_i = 1'b0;
    imem_bus.imem_rsp_data_i  = '0;

    // stall rdy inj | req addr | vd pc | cnt
    add(0,1,0, 1,32'h00, 0,32'h00, 0);
    add(0,1,0, 0,32'h00, 0,32'h00, 0);
    add(0,1,0, 1,32'h04, 1,32'h00, 0);
    add(0,1,0, 0,32'h00, 0,32'h00, 0);
    add(0,1,0, 1,32'h08, 1,32'h04, 0);
    add(0,1,0, 0,32'h00, 0,32'h04, 0);
    add(0,0,0, 1,32'h0C, 1,32'h08, 0);
    add(0,1,0, 1,32'h0C, 0,32'h08, 0);
    add(1,1,0, 0,32'h00, 0,32'h08, 0);
    add(1,1,0, 1,32'h10, 0,32'h08, 1);
    add(1,1,0, 0,32'h00, 0,32'h08, 1);
    add(1,1,0, 1,32'h14, 0,32'h08, 2);
    add(1,1,0, 0,32'h00, 0,32'h08, 2);
    add(1,1,0, 1,32'h18, 0,32'h08, 3);
    add(1,1,0, 0,32'h00, 0,32'h08, 3);
    add(1,1,0, 0,32'h00, 0,32'h08, 4);
    add(1,1,1, 0,32'h00, 0,32'h08, 4);
    add(1,1,0, 0,32'h00, 0,32'h08, 4);
    add(0,1,0, 0,32'h00, 0,32'h08, 4);
    add(0,1,0, 1,32'h1C, 1,32'h0C, 3);
    add(0,1,0, 0,32'h00, 1,32'h10, 2);
    add(0,1,0, 1,32'h20, 1,32'h14, 2);
    add(0,1,0, 0,32'h00, 1,32'h18, 1);
    add(0,1,0, 1,32'h24, 1,32'h1C, 1);
    add(0,1,0, 0,32'h00, 1,32'h20, 0);
    add(0,1,0, 1,32'h28, 1,32'h24, 0);

    repeat (3) @(negedge clk);
    #1;
    check_req("reset", 1'b0, 32'h0);
    check_dec("reset", 1'b0, 32'h0);
    check("reset_instr_d", instr_d, 32'h0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check_state("reset", ST_IDLE);
    rst = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      step(vt[i].stall, 1'b0, 32'h0, vt[i].ready, vt[i].inject);
      check_req($sformatf("vec%0d", i), vt[i].exp_req, vt[i].exp_addr);
      check_dec($sformatf("vec%0d", i), vt[i].exp_vd, vt[i].exp_pc);
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].exp_cnt));
    end

    // Redirect in the same cycle as the response: response dropped, target realigned.
    step(0, 1, 32'h203, 1, 0);
    check_req("redir_same", 1'b0, 32'h0);
    step(0, 0, 32'h0, 1, 0);
    check_state("redir_same_next", ST_IDLE);
    check_req("redir_aligned", 1'b1, 32'h200);
    check("redir_same_valid_d", 32'(valid_d), 32'd0);
    check("redir_same_count", 32'(fifo_count), 32'd0);
    step(0, 0, 32'h0, 1, 0);
    check("redir_same_valid_d2", 32'(valid_d), 32'd0);
    lat = 3;
    step(0, 0, 32'h0, 1, 0);
    check_dec("redir_first", 1'b1, 32'h200);
    check_req("redir_first", 1'b1, 32'h204);

    // Redirect while a slow request is outstanding: its response must be squashed.
    step(0, 1, 32'h10, 1, 0);
    check_req("drop1_redir", 1'b0, 32'h0);
    step(0, 0, 32'h0, 1, 0);
    check_state("drop1", ST_WAIT_DROP);
    check_req("drop1", 1'b0, 32'h0);
    step(0, 0, 32'h0, 1, 0);
    check_req("drop1_rsp", 1'b0, 32'h0);
    step(0, 0, 32'h0, 1, 0);
    check_state("drop1_done", ST_IDLE);
    check_req("drop1_done", 1'b1, 32'h10);
    step(0, 1, 32'h100, 1, 0);
    check_req("drop2_redir", 1'b0, 32'h0);
    step(0, 0, 32'h0, 1, 0);
    check_state("drop2", ST_WAIT_DROP);
    check_dec("drop2", 1'b0, 32'h200);
    check("drop2_count", 32'(fifo_count), 32'd0);
    check_req("drop2", 1'b0, 32'h0);
    step(0, 0, 32'h0, 1, 0);
    check_req("drop2_rsp", 1'b0, 32'h0);
    check("drop2_rsp_valid_d", 32'(valid_d), 32'd0);
    lat = 1;
    step(0, 0, 32'h0, 1, 0);
    check_req("drop2_next", 1'b1, 32'h100);
    check_dec("drop2_next", 1'b0, 32'h200);
    step(0, 0, 32'h0, 1, 0);
    check_dec("drop2_wait", 1'b0, 32'h200);

    // Redirect together with stall: buffered entries and the decode register are both squashed.
    step(1, 0, 32'h0, 1, 0);
    check_dec("rs_hold0", 1'b1, 32'h100);
    check_req("rs_hold0", 1'b1, 32'h104);
    step(1, 0, 32'h0, 1, 0);
    check_dec("rs_hold1", 1'b1, 32'h100);
    check("rs_hold1_count", 32'(fifo_count), 32'd0);
    step(1, 0, 32'h0, 1, 0);
    check_req("rs_hold2", 1'b1, 32'h108);
    check("rs_hold2_count", 32'(fifo_count), 32'd1);
    step(1, 0, 32'h0, 1, 0);
    check("rs_hold3_count", 32'(fifo_count), 32'd1);
    step(1, 1, 32'h300, 1, 0);
    check("rs_redir_count", 32'(fifo_count), 32'd2);
    check("rs_redir_valid_d", 32'(valid_d), 32'd1);
    check_req("rs_redir", 1'b0, 32'h0);
    step(1, 0, 32'h0, 1, 0);
    check("rs_after_valid_d", 32'(valid_d), 32'd0);
    check("rs_after_count", 32'(fifo_count), 32'd0);
    check_req("rs_after", 1'b1, 32'h300);
    step(0, 0, 32'h0, 1, 0);
    check("rs_rsp_valid_d", 32'(valid_d), 32'd0);
    lat = 5;
    step(0, 0, 32'h0, 1, 0);
    check_dec("rs_target", 1'b1, 32'h300);
    check_req("rs_target", 1'b1, 32'h304);

    // Reset while a request is outstanding; the late response lands while reset is still held.
    step(0, 0, 32'h0, 1, 0);
    check_state("mid_wait", ST_WAIT);
    rst = 1'b0;
    #1;
    check_req("mid_reset", 1'b0, 32'h0);
    check_dec("mid_reset", 1'b0, 32'h0);
    check("mid_reset_instr_d", instr_d, 32'h0);
    check("mid_reset_pc_plus4_d", pc_plus4_d, 32'h0);
    check("mid_reset_count", 32'(fifo_count), 32'd0);
    check_state("mid_reset", ST_IDLE);
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, 0);
    check("mid_reset_rsp_seen", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    lat = 1;
    step(0, 0, 32'h0, 1, 0);
    check_state("rel_first", ST_IDLE);
    check_req("rel_first", 1'b1, 32'h0);
    check("rel_first_valid_d", 32'(valid_d), 32'd0);
    step(0, 0, 32'h0, 1, 0);
    check_state("rel_wait", ST_WAIT);
    step(0, 0, 32'h0, 1, 0);
    check_dec("rel_dec", 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
